axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Read-channel controller for the AXI interconnect: arbitrates AR requests from masters M0 and M1, decodes the winning address to slave S0, S1 or the default slave, and drives the AR and R valid/ready handshakes for the granted path. It holds the grant until the last R beat completes. It publishes the selected master and slave so that the AR payload muxes and R payload muxes alongside it can steer ID, address and data. It sits between the master-side ports and slave-side ports of the interconnect top, in place of free-running read-address/read-data routing.

## Interface
Parameters:
- ADDR_BITS, 32, address width
- S0_BASE, 32'h0000_0000, S0 region base
- S1_BASE, 32'h0001_0000, S1 region base
- REGION_BITS, 16, low bits ignored in decode; a region matches when ADDR[ADDR_BITS-1:REGION_BITS] equals BASE[ADDR_BITS-1:REGION_BITS]

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- ARVALID_M0, ARVALID_M1  in  1  master AR valid
- ARADDR_M0, ARADDR_M1  in  ADDR_BITS  master AR address
- ARREADY_M0, ARREADY_M1  out  1  AR ready to masters
- ARVALID_S0, ARVALID_S1, ARVALID_DEF  out  1  AR valid to slaves
- ARREADY_S0, ARREADY_S1, ARREADY_DEF  in  1  AR ready from slaves
- RVALID_S0, RVALID_S1, RVALID_DEF  in  1  R valid from slaves
- RLAST_S0, RLAST_S1, RLAST_DEF  in  1  R last from slaves
- RREADY_S0, RREADY_S1, RREADY_DEF  out  1  R ready to slaves
- RVALID_M0, RVALID_M1  out  1  R valid to masters
- RREADY_M0, RREADY_M1  in  1  R ready from masters
- mst_sel  out  1  granted master (0 = M0, 1 = M1)
- slv_sel  out  2  selected slave (2'd0 = S0, 2'd1 = S1, 2'd2 = default)
- busy  out  1  high when the state is not IDLE

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - All handshake outputs are 0.
  - If any ARVALID_Mx is high, pick a winner, register mst_sel, decode the winner's ARADDR into slv_sel, then go to ADDR.
- Arbitration is round-robin.
  - With one requester, that requester wins.
  - With both requesting, the master not granted last time wins.
  - After reset, M0 has priority.
  - The priority pointer updates only when an arbitration happens.
- Decode:
  - S0 region → slv_sel=0.
  - Otherwise S1 region → slv_sel=1.
  - Otherwise → 2 (default slave).
  - If both regions match, S0 takes precedence.
- ADDR:
  - The ARVALID_S<slv_sel> output equals ARVALID_M<mst_sel>.
  - The ARREADY_M<mst_sel> output equals ARREADY_S<slv_sel>.
  - When both are high at a clock edge (AR handshake), go to DATA.
  - The ungranted master's ARREADY stays 0.
- DATA:
  - The RVALID_M<mst_sel> output equals RVALID_S<slv_sel>.
  - The RREADY_S<slv_sel> output equals RREADY_M<mst_sel>.
  - When RVALID, RREADY and RLAST of the selected slave are all high at a clock edge, go to IDLE.
  - Beats without RLAST keep the FSM in DATA.
- Unselected outputs are always 0. mst_sel and slv_sel hold their values outside ADDR/DATA.
- Only one read transaction is outstanding at a time; masters are never granted concurrently.
- If the owner deasserts ARVALID in ADDR, that is a protocol violation. The FSM stays in ADDR with no handshake.

## Timing
- Reset (ARESETn=0, asynchronous):
  - state=IDLE, mst_sel=0, slv_sel=0, priority to M0.
  - All ready/valid outputs are 0 and busy=0.
  - Reset asserted mid-burst aborts the transaction; no cleanup beats are issued.
- Arbitration latency:
  - ARVALID_Mx is sampled at edge k.
  - ARVALID_S is visible during cycle k+1.
  - With the slave ready, the AR handshake completes at edge k+1 and DATA starts in cycle k+2.
- All handshake outputs are combinational from registered state/selects plus the pass-through inputs; there are no registered stalls on the handshake path.
- Completion: the RLAST handshake at edge n gives IDLE in cycle n+1. The next grant can reach ADDR at cycle n+2, so there is a 1-cycle IDLE bubble between transactions.
- Requests arriving during ADDR or DATA wait. Their ARREADY stays 0, and they must hold ARVALID (AXI rule).

## Test plan
- Single M0 read of 0x0000_0040 with len 0 and S0 immediately ready:
  - ARVALID_S0 is high 1 cycle after the request; ARREADY_M0 pulses.
  - One R beat with RLAST routes to RVALID_M0.
  - busy clears the cycle after the beat; mst_sel=0, slv_sel=0.
- M1 read of 0x0001_0010 with a 4-beat burst, S1 inserting 2 ARREADY wait cycles and RREADY_M1 stalls:
  - slv_sel=1.
  - All 4 beats pass through, with RREADY_S1 following RREADY_M1.
  - The FSM leaves DATA only on the 4th (RLAST) handshake.
- Both masters valid in the same cycle after reset:
  - M0 is granted first and M1 next.
  - Then with both valid again, M0 is granted, demonstrating alternation.
  - M1's ARREADY_M1 is 0 throughout M0's transaction.
- Read of 0x2000_0000:
  - slv_sel=2 and ARVALID_DEF asserted.
  - The default slave response is routed to the requester, with ARVALID_S0 and ARVALID_S1 held at 0.
- ARESETn pulsed low during DATA of a burst:
  - All outputs drop to 0 asynchronously and the FSM is in IDLE.
  - The next request is granted normally, with M0 priority restored.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Read-channel handshake bundle between two AXI masters and three slave ports.
// The master modport is the arbiter's view; the slave modport is the surrounding fabric's view.
interface axi_read_arbiter_if #(
   parameter int ADDR_BITS = 32
);
   logic                 ARVALID_M0;
   logic                 ARVALID_M1;
   logic [ADDR_BITS-1:0] ARADDR_M0;
   logic [ADDR_BITS-1:0] ARADDR_M1;
   logic                 ARREADY_M0;
   logic                 ARREADY_M1;
   logic                 ARVALID_S0;
   logic                 ARVALID_S1;
   logic                 ARVALID_DEF;
   logic                 ARREADY_S0;
   logic                 ARREADY_S1;
   logic                 ARREADY_DEF;
   logic                 RVALID_S0;
   logic                 RVALID_S1;
   logic                 RVALID_DEF;
   logic                 RLAST_S0;
   logic                 RLAST_S1;
   logic                 RLAST_DEF;
   logic                 RREADY_S0;
   logic                 RREADY_S1;
   logic                 RREADY_DEF;
   logic                 RVALID_M0;
   logic                 RVALID_M1;
   logic                 RREADY_M0;
   logic                 RREADY_M1;

   modport master (
      input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1,
      output ARREADY_M0, ARREADY_M1,
      output ARVALID_S0, ARVALID_S1, ARVALID_DEF,
      input  ARREADY_S0, ARREADY_S1, ARREADY_DEF,
      input  RVALID_S0, RVALID_S1, RVALID_DEF,
      input  RLAST_S0, RLAST_S1, RLAST_DEF,
      output RREADY_S0, RREADY_S1, RREADY_DEF,
      output RVALID_M0, RVALID_M1,
      input  RREADY_M0, RREADY_M1
   );

   modport slave (
      output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1,
      input  ARREADY_M0, ARREADY_M1,
      input  ARVALID_S0, ARVALID_S1, ARVALID_DEF,
      output ARREADY_S0, ARREADY_S1, ARREADY_DEF,
      output RVALID_S0, RVALID_S1, RVALID_DEF,
      output RLAST_S0, RLAST_S1, RLAST_DEF,
      input  RREADY_S0, RREADY_S1, RREADY_DEF,
      input  RVALID_M0, RVALID_M1,
      output RREADY_M0, RREADY_M1
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// AXI read-channel arbiter: round-robin grant between M0/M1, address decode to S0/S1/default,
// and AR/R handshake steering for the single outstanding transaction.
module axi_read_arbiter #(
   parameter int                   ADDR_BITS   = 32,
   parameter logic [ADDR_BITS-1:0] S0_BASE     = 32'h0000_0000,
   parameter logic [ADDR_BITS-1:0] S1_BASE     = 32'h0001_0000,
   parameter int                   REGION_BITS = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   axi_read_arbiter_if.master        bus,
   output logic                      mst_sel,
   output logic [1:0]                slv_sel,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t     state_r;
   logic       prio_r;
   logic       mst_sel_r;
   logic [1:0] slv_sel_r;
   logic       busy_r;

   logic       any_req_s;
   logic       win_s;
   logic [1:0] win_slv_s;
   logic       sel_arvalid_m_s;
   logic       sel_rready_m_s;
   logic       sel_arready_s_s;
   logic       sel_rvalid_s_s;
   logic       sel_rlast_s_s;
   logic       ar_hs_s;
   logic       r_last_hs_s;
   logic [1:0] arready_m_s;
   logic [1:0] rvalid_m_s;
   logic [2:0] arvalid_s_s;
   logic [2:0] rready_s_s;

   // S0 wins when both regions overlap.
   function automatic logic [1:0] decode_region(input logic [ADDR_BITS-1:0] addr);
      logic [1:0] region;
      if (addr[ADDR_BITS-1:REGION_BITS] == S0_BASE[ADDR_BITS-1:REGION_BITS]) begin
         region = 2'd0;
      end else if (addr[ADDR_BITS-1:REGION_BITS] == S1_BASE[ADDR_BITS-1:REGION_BITS]) begin
         region = 2'd1;
      end else begin
         region = 2'd2;
      end
      return region;
   endfunction

   // Round-robin winner selection and decode of the winner's address.
   always_comb begin
      any_req_s = bus.ARVALID_M0 | bus.ARVALID_M1;
      if (bus.ARVALID_M0 && bus.ARVALID_M1) begin
         win_s = prio_r;
      end else if (bus.ARVALID_M1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      if (win_s) begin
         win_slv_s = decode_region(bus.ARADDR_M1);
      end else begin
         win_slv_s = decode_region(bus.ARADDR_M0);
      end
   end

   // Selected-path view of the inputs, driven by the registered selects.
   always_comb begin
      sel_arvalid_m_s = mst_sel_r ? bus.ARVALID_M1 : bus.ARVALID_M0;
      sel_rready_m_s  = mst_sel_r ? bus.RREADY_M1  : bus.RREADY_M0;
      case (slv_sel_r)
         2'd0: begin
            sel_arready_s_s = bus.ARREADY_S0;
            sel_rvalid_s_s  = bus.RVALID_S0;
            sel_rlast_s_s   = bus.RLAST_S0;
         end
         2'd1: begin
            sel_arready_s_s = bus.ARREADY_S1;
            sel_rvalid_s_s  = bus.RVALID_S1;
            sel_rlast_s_s   = bus.RLAST_S1;
         end
         2'd2: begin
            sel_arready_s_s = bus.ARREADY_DEF;
            sel_rvalid_s_s  = bus.RVALID_DEF;
            sel_rlast_s_s   = bus.RLAST_DEF;
         end
         default: begin
            sel_arready_s_s = 1'b0;
            sel_rvalid_s_s  = 1'b0;
            sel_rlast_s_s   = 1'b0;
         end
      endcase
      ar_hs_s     = sel_arvalid_m_s & sel_arready_s_s;
      r_last_hs_s = sel_rvalid_s_s & sel_rready_m_s & sel_rlast_s_s;
   end

   // Grant FSM with registered selects, priority pointer and busy flag.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_r   <= IDLE;
         prio_r    <= 1'b0;
         mst_sel_r <= 1'b0;
         slv_sel_r <= 2'd0;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  mst_sel_r <= win_s;
                  slv_sel_r <= win_slv_s;
                  prio_r    <= ~win_s;
                  state_r   <= ADDR;
                  busy_r    <= 1'b1;
               end
            end
            ADDR: begin
               if (ar_hs_s) begin
                  state_r <= DATA;
               end
            end
            DATA: begin
               if (r_last_hs_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Handshake steering: only the granted master/slave pair sees any activity.
   always_comb begin
      arready_m_s = 2'b00;
      rvalid_m_s  = 2'b00;
      arvalid_s_s = 3'b000;
      rready_s_s  = 3'b000;
      if (state_r == ADDR) begin
         arready_m_s[mst_sel_r] = sel_arready_s_s;
         case (slv_sel_r)
            2'd0:    arvalid_s_s = {2'b00, sel_arvalid_m_s};
            2'd1:    arvalid_s_s = {1'b0, sel_arvalid_m_s, 1'b0};
            2'd2:    arvalid_s_s = {sel_arvalid_m_s, 2'b00};
            default: arvalid_s_s = 3'b000;
         endcase
      end else if (state_r == DATA) begin
         rvalid_m_s[mst_sel_r] = sel_rvalid_s_s;
         case (slv_sel_r)
            2'd0:    rready_s_s = {2'b00, sel_rready_m_s};
            2'd1:    rready_s_s = {1'b0, sel_rready_m_s, 1'b0};
            2'd2:    rready_s_s = {sel_rready_m_s, 2'b00};
            default: rready_s_s = 3'b000;
         endcase
      end else begin
         arready_m_s = 2'b00;
         rvalid_m_s  = 2'b00;
      end
   end

   assign bus.ARREADY_M0  = arready_m_s[0];
   assign bus.ARREADY_M1  = arready_m_s[1];
   assign bus.RVALID_M0   = rvalid_m_s[0];
   assign bus.RVALID_M1   = rvalid_m_s[1];
   assign bus.ARVALID_S0  = arvalid_s_s[0];
   assign bus.ARVALID_S1  = arvalid_s_s[1];
   assign bus.ARVALID_DEF = arvalid_s_s[2];
   assign bus.RREADY_S0   = rready_s_s[0];
   assign bus.RREADY_S1   = rready_s_s[1];
   assign bus.RREADY_DEF  = rready_s_s[2];

   assign mst_sel = mst_sel_r;
   assign slv_sel = slv_sel_r;
   assign busy    = busy_r;

endmodule
